// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared types, helpers and parameter checks for the counter bank
package mod_counter_pkg;

    // Per-channel update rule, listed from highest to lowest priority
    typedef enum logic [1:0] {
        OP_CLR   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2,
        OP_HOLD  = 2'd3
    } op_e;

    // Ceiling log2; returns 0 for values of 0 and 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // The modulus must wrap at least once and fit in the channel width
    function automatic bit modulus_legal(input int width, input int modulus);
        return (width >= 2) && (width <= 16) &&
               (modulus >= 2) && (clog2(modulus) <= width);
    endfunction

endpackage

// File: rtl/mod_counter_channel.sv
// rtl/mod_counter_channel.sv - one counter channel: register, next-state rules and terminal count
module mod_counter_channel
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_at_end;
    op_e              w_op;

    // Pick the winning rule; clear and load do not need the enable
    always_comb begin
        w_op = OP_HOLD;
        if (i_clr) begin
            w_op = OP_CLR;
        end else if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_en) begin
            w_op = OP_COUNT;
        end
    end

    // Wrap point in the current direction; >= catches loaded values beyond the modulus
    always_comb begin
        w_at_end = i_up ? (r_q >= LAST) : (r_q == '0);
    end

    // Next count value for the selected rule
    always_comb begin
        w_q_next = r_q;
        case (w_op)
            OP_CLR:   w_q_next = '0;
            OP_LOAD:  w_q_next = i_d;
            OP_COUNT: begin
                if (i_up) begin
                    w_q_next = w_at_end ? '0 : r_q + WIDTH'(1);
                end else begin
                    w_q_next = w_at_end ? LAST : r_q - WIDTH'(1);
                end
            end
            default:  w_q_next = r_q;
        endcase
    end

    // Count register, updated on the falling edge
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_q  = r_q;
    assign o_tc = (w_op == OP_COUNT) && w_at_end;

endmodule

// File: rtl/mod_counter_bank.sv
// rtl/mod_counter_bank.sv - bank of modulo counters; MOD_COUNTER_BANK_CASCADE_EN adds TC-to-enable chaining
module mod_counter_bank
    import mod_counter_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    input  logic [CHANNELS-1:0]       CLR,
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       UP,
`ifdef MOD_COUNTER_BANK_CASCADE_EN
    input  logic [CHANNELS-1:0]       CASC,
`endif
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       TC
);

    if (!modulus_legal(WIDTH, MODULUS) || CHANNELS < 1 || CHANNELS > 8) begin : g_bad_params
        $error("mod_counter_bank: illegal CHANNELS/WIDTH/MODULUS combination");
    end

`ifdef MOD_COUNTER_BANK_CASCADE_EN
    // The first channel has nothing below it to chain from
    logic w_casc0_unused;
    assign w_casc0_unused = CASC[0];
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic w_eff_en;
        logic w_tc;

`ifdef MOD_COUNTER_BANK_CASCADE_EN
        // Chained channels only advance when the channel below is about to wrap
        if (i == 0) begin : g_head
            assign w_eff_en = EN[i];
        end else begin : g_link
            assign w_eff_en = EN[i] & (~CASC[i] | g_ch[i-1].w_tc);
        end
`else
        assign w_eff_en = EN[i];
`endif

        mod_counter_channel #(
            .WIDTH   (WIDTH),
            .MODULUS (MODULUS)
        ) u_channel (
            .i_clk   (CLK),
            .i_rst_n (CLR_N),
            .i_clr   (CLR[i]),
            .i_load  (LOAD[i]),
            .i_en    (w_eff_en),
            .i_up    (UP[i]),
            .i_d     (D[i*WIDTH +: WIDTH]),
            .o_q     (Q[i*WIDTH +: WIDTH]),
            .o_tc    (w_tc)
        );

        assign TC[i] = w_tc;
    end

endmodule
